// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with bypassed register file, immediate generation, load-use stall and ID/EX register
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_reg_dst,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              stall_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_sext_imm,
  output logic [DATA_W-1:0] out_sext_imm_sl2,
  output logic [DATA_W-1:0] out_zext_imm,
  output logic [ADDR_W-1:0] out_rs,
  output logic [ADDR_W-1:0] out_rt,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic              out_reg_write,
  output logic              out_mem_read
);
  logic [DATA_W-1:0] rf_q [NREG];
  logic              valid_q, reg_write_q, mem_read_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, sext_q, sl2_q, zext_q;
  logic [ADDR_W-1:0] rs_q, rt_q, wr_addr_q;
  logic              wb_ok, haz;
  logic [DATA_W-1:0] rs_data_d, rt_data_d, sext_d, sl2_d, zext_d;
  logic [ADDR_W-1:0] wr_addr_d;
  // Register-file reads bypass the same-cycle writeback; r0 and out-of-range addresses read zero
  always_comb begin
    wb_ok     = wb_we & (wb_addr != '0);
    rs_data_d = (in_rs == '0 || int'(in_rs) >= NREG) ? '0 :
                (wb_ok && wb_addr == in_rs) ? wb_data : rf_q[in_rs];
    rt_data_d = (in_rt == '0 || int'(in_rt) >= NREG) ? '0 :
                (wb_ok && wb_addr == in_rt) ? wb_data : rf_q[in_rt];
    sext_d    = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    sl2_d     = {sext_d[DATA_W-3:0], 2'b00};
    zext_d    = {{(DATA_W-IMM_W){1'b0}}, in_imm};
    wr_addr_d = in_reg_dst ? in_rd : in_rt;
    haz       = valid_q & mem_read_q & (wr_addr_q != '0) & in_valid &
                ((wr_addr_q == in_rs) | (wr_addr_q == in_rt));
    stall_out = (haz | ex_stall) & ~flush;
  end
  // Register file: cleared by reset, written only from the writeback port, r0 never written
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    else if (wb_ok && int'(wb_addr) < NREG) rf_q[wb_addr] <= wb_data;
  end
  // ID/EX register: reset, then flush, then hold on downstream stall, then bubble on load-use, else load
  always_ff @(posedge clk) begin
    if (reset) begin
      {valid_q, reg_write_q, mem_read_q} <= '0;
      {rs_data_q, rt_data_q, sext_q, sl2_q, zext_q} <= '0;
      {rs_q, rt_q, wr_addr_q} <= '0;
    end else if (flush || (!ex_stall && haz)) begin
      {valid_q, reg_write_q, mem_read_q} <= '0;
    end else if (!ex_stall) begin
      valid_q     <= in_valid;
      reg_write_q <= in_valid & in_reg_write;
      mem_read_q  <= in_valid & in_mem_read;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      sext_q      <= sext_d;
      sl2_q       <= sl2_d;
      zext_q      <= zext_d;
      rs_q        <= in_rs;
      rt_q        <= in_rt;
      wr_addr_q   <= wr_addr_d;
    end
  end
  assign out_valid        = valid_q;
  assign out_reg_write    = reg_write_q;
  assign out_mem_read     = mem_read_q;
  assign out_rs_data      = rs_data_q;
  assign out_rt_data      = rt_data_q;
  assign out_sext_imm     = sext_q;
  assign out_sext_imm_sl2 = sl2_q;
  assign out_zext_imm     = zext_q;
  assign out_rs           = rs_q;
  assign out_rt           = rt_q;
  assign out_wr_addr      = wr_addr_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed checks of register file, bypass, immediates, hazards, stall/flush and reset
module tb_id_stage_pipe;
  logic        clk = 0, reset, in_valid, in_reg_dst, in_reg_write, in_mem_read;
  logic [4:0]  in_rs, in_rt, in_rd, wb_addr;
  logic [15:0] in_imm;
  logic        wb_we, ex_stall, flush, stall_out, out_valid, out_reg_write, out_mem_read;
  logic [31:0] wb_data, out_rs_data, out_rt_data, out_sext_imm, out_sext_imm_sl2, out_zext_imm;
  logic [4:0]  out_rs, out_rt, out_wr_addr;
  int checks = 0, fails = 0;

  id_stage_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_reg_dst(in_reg_dst), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush),
    .stall_out(stall_out), .out_valid(out_valid), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
    .out_sext_imm(out_sext_imm), .out_sext_imm_sl2(out_sext_imm_sl2), .out_zext_imm(out_zext_imm),
    .out_rs(out_rs), .out_rt(out_rt), .out_wr_addr(out_wr_addr),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    reset = 0; in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
    in_reg_dst = 0; in_reg_write = 0; in_mem_read = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; ex_stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1; cyc(); cyc(); reset = 0; #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_rs_data !== 32'h0) begin fails++; $display("FAIL reset_rs_data: got %h expected 0", out_rs_data); end
    checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall_out); end
  endtask

  task automatic test_write_read();
    clear_in();
    wb_we = 1; wb_addr = 5; wb_data = 32'h1234; cyc();
    wb_we = 0; in_valid = 1; in_rs = 5; in_reg_write = 1; cyc();
    checks++; if (out_rs_data !== 32'h0000_1234) begin fails++; $display("FAIL wr_rd_data: got %h expected 00001234", out_rs_data); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL wr_rd_valid: got %b expected 1", out_valid); end
    checks++; if (out_reg_write !== 1'b1) begin fails++; $display("FAIL wr_rd_regwrite: got %b expected 1", out_reg_write); end
    checks++; if (out_rs !== 5'd5) begin fails++; $display("FAIL wr_rd_rs_tag: got %0d expected 5", out_rs); end
  endtask

  task automatic test_bypass();
    clear_in();
    wb_we = 1; wb_addr = 7; wb_data = 32'hDEAD_BEEF; in_valid = 1; in_rt = 7; cyc();
    checks++; if (out_rt_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bypass_rt: got %h expected deadbeef", out_rt_data); end
    wb_we = 0; in_rt = 7; in_rs = 5; cyc();
    checks++; if (out_rt_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL stored_rt: got %h expected deadbeef", out_rt_data); end
    checks++; if (out_rs_data !== 32'h0000_1234) begin fails++; $display("FAIL stored_rs: got %h expected 00001234", out_rs_data); end
  endtask

  task automatic test_zero_reg();
    clear_in();
    wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF; in_valid = 1; in_rs = 0; cyc();
    checks++; if (out_rs_data !== 32'h0) begin fails++; $display("FAIL r0_bypass: got %h expected 0", out_rs_data); end
    wb_we = 0; cyc();
    checks++; if (out_rs_data !== 32'h0) begin fails++; $display("FAIL r0_stored: got %h expected 0", out_rs_data); end
  endtask

  task automatic test_wr_addr();
    clear_in();
    in_valid = 1; in_rt = 2; in_rd = 9; in_reg_dst = 1; cyc();
    checks++; if (out_wr_addr !== 5'd9) begin fails++; $display("FAIL wr_addr_rd: got %0d expected 9", out_wr_addr); end
    in_reg_dst = 0; cyc();
    checks++; if (out_wr_addr !== 5'd2) begin fails++; $display("FAIL wr_addr_rt: got %0d expected 2", out_wr_addr); end
  endtask

  task automatic test_load_use();
    clear_in();
    in_valid = 1; in_rs = 1; in_rt = 3; in_mem_read = 1; in_reg_write = 1; cyc();
    checks++; if (out_mem_read !== 1'b1) begin fails++; $display("FAIL lu_load_memread: got %b expected 1", out_mem_read); end
    in_rs = 3; in_rt = 2; in_rd = 9; in_reg_dst = 1; in_mem_read = 0; #1;
    checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b expected 1", stall_out); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble_valid: got %b expected 0", out_valid); end
    checks++; if (out_reg_write !== 1'b0) begin fails++; $display("FAIL lu_bubble_regwrite: got %b expected 0", out_reg_write); end
    checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL lu_stall_release: got %b expected 0", stall_out); end
    cyc();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lu_issue_valid: got %b expected 1", out_valid); end
    checks++; if (out_wr_addr !== 5'd9) begin fails++; $display("FAIL lu_issue_wr: got %0d expected 9", out_wr_addr); end
    in_rs = 1; in_rt = 3; in_reg_dst = 0; in_mem_read = 1; cyc();
    in_rs = 0; in_rt = 3; in_mem_read = 0; #1;
    checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL lu_stall_rt: got %b expected 1", stall_out); end
    flush = 1; #1;
    checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL lu_flush_stall: got %b expected 0", stall_out); end
    cyc(); flush = 0;
  endtask

  task automatic test_imm();
    clear_in();
    in_valid = 1; in_imm = 16'h8001; cyc();
    checks++; if (out_sext_imm !== 32'hFFFF_8001) begin fails++; $display("FAIL sext_neg: got %h expected ffff8001", out_sext_imm); end
    checks++; if (out_sext_imm_sl2 !== 32'hFFFE_0004) begin fails++; $display("FAIL sl2_neg: got %h expected fffe0004", out_sext_imm_sl2); end
    checks++; if (out_zext_imm !== 32'h0000_8001) begin fails++; $display("FAIL zext_neg: got %h expected 00008001", out_zext_imm); end
    in_imm = 16'h7FFC; cyc();
    checks++; if (out_sext_imm !== 32'h0000_7FFC) begin fails++; $display("FAIL sext_pos: got %h expected 00007ffc", out_sext_imm); end
    checks++; if (out_sext_imm_sl2 !== 32'h0001_FFF0) begin fails++; $display("FAIL sl2_pos: got %h expected 0001fff0", out_sext_imm_sl2); end
  endtask

  task automatic test_stall_flush();
    clear_in();
    in_valid = 1; in_rs = 4; in_imm = 16'h0010; in_reg_write = 1; cyc();
    ex_stall = 1; in_rs = 6; in_imm = 16'h0020; in_reg_write = 0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++; if (out_rs !== 5'd4) begin fails++; $display("FAIL hold_rs[%0d]: got %0d expected 4", k, out_rs); end
      checks++; if (out_sext_imm !== 32'h10) begin fails++; $display("FAIL hold_imm[%0d]: got %h expected 00000010", k, out_sext_imm); end
      checks++; if (out_reg_write !== 1'b1) begin fails++; $display("FAIL hold_regwrite[%0d]: got %b expected 1", k, out_reg_write); end
      checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL hold_stall[%0d]: got %b expected 1", k, stall_out); end
    end
    flush = 1; cyc();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    checks++; if (out_reg_write !== 1'b0) begin fails++; $display("FAIL flush_regwrite: got %b expected 0", out_reg_write); end
    flush = 0; ex_stall = 0; in_rs = 5; in_mem_read = 1; cyc();
    ex_stall = 1; reset = 1; cyc();
    reset = 0; ex_stall = 0; in_rs = 5; in_mem_read = 0; #1;
    checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b expected 0", stall_out); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (out_mem_read !== 1'b0) begin fails++; $display("FAIL rst_memread: got %b expected 0", out_mem_read); end
    checks++; if (out_rs !== 5'd0) begin fails++; $display("FAIL rst_rs: got %0d expected 0", out_rs); end
    checks++; if (out_rs_data !== 32'h0) begin fails++; $display("FAIL rst_rs_data: got %h expected 0", out_rs_data); end
    cyc();
    checks++; if (out_rs_data !== 32'h0) begin fails++; $display("FAIL rst_rf_cleared: got %h expected 0", out_rs_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_wr_addr();
    test_load_use();
    test_imm();
    test_stall_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, datapath width; NREG, 32, register count; ADDR_W, 5, register address width (2**ADDR_W >= NREG); IMM_W, 16, immediate width.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  clock
- reset  in  1  reset (see REQ-003)
- in_valid  in  1  decode input holds an instruction
- in_rs  in  ADDR_W  source register 1
- in_rt  in  ADDR_W  source register 2
- in_rd  in  ADDR_W  R-type destination
- in_imm  in  IMM_W  immediate field
- in_reg_dst  in  1  1 = write in_rd, 0 = write in_rt
- in_reg_write  in  1  instruction writes a register
- in_mem_read  in  1  instruction is a load
- wb_we  in  1  writeback write enable
- wb_addr  in  ADDR_W  writeback address
- wb_data  in  DATA_W  writeback data
- ex_stall  in  1  downstream cannot accept
- flush  in  1  squash the instruction in decode
- stall_out  out  1  upstream holds its instruction
- out_valid  out  1  ID/EX register holds an instruction
- out_rs_data, out_rt_data  out  DATA_W  operands
- out_sext_imm  out  DATA_W  sign-extended immediate
- out_sext_imm_sl2  out  DATA_W  out_sext_imm shifted left by 2
- out_zext_imm  out  DATA_W  zero-extended immediate
- out_rs, out_rt, out_wr_addr  out  ADDR_W  forwarding tags and destination
- out_reg_write, out_mem_read  out  1  registered control signals
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 Register file SHALL hold NREG x DATA_W entries; entry 0 SHALL always read 0 and ignore writes.
REQ-005 A write SHALL occur on the rising clk edge when wb_we=1 and wb_addr!=0.
REQ-006 Reads SHALL be combinational with write bypass: if wb_we=1, wb_addr!=0 and wb_addr equals the read address, the operand SHALL be wb_data in the same cycle.
REQ-007 Write address SHALL be in_rd when in_reg_dst=1, otherwise in_rt.
REQ-008 Immediate outputs SHALL be computed from in_imm and registered with the operands; the sign extension SHALL replicate in_imm[IMM_W-1].
REQ-009 Latency SHALL be one cycle: the ID/EX register captures on the edge after inputs are presented.
REQ-010 Load-use hazard (haz) SHALL be asserted when out_valid=1, out_mem_read=1, out_wr_addr!=0, in_valid=1, and out_wr_addr equals in_rs or in_rt.
REQ-011 stall_out SHALL equal (haz | ex_stall) & ~flush, combinationally.
REQ-012 Update priority each edge: reset > flush (out_valid<=0) > ex_stall (ID/EX holds every field) > haz (bubble: out_valid<=0, out_reg_write<=0, out_mem_read<=0) > normal load (out_valid<=in_valid).
REQ-013 When out_valid=0, out_reg_write and out_mem_read SHALL be 0.
REQ-014 A bubble or invalid input SHALL never cause a register file write.

Reset
REQ-015 While reset=1 at an edge, all register file entries and all ID/EX outputs SHALL become 0.
REQ-016 Reset SHALL override flush, ex_stall and hazard, and any in-flight instruction SHALL be discarded.
REQ-017 stall_out SHALL be 0 in the cycle after reset, because out_valid=0.

Verification
REQ-018 Write r5=0x1234 via wb; next cycle decode rs=5 -> out_rs_data=0x00001234 one cycle later.
REQ-019 Same cycle: wb_we=1, wb_addr=7, wb_data=0xDEADBEEF, and decode rt=7 -> out_rt_data=0xDEADBEEF (bypass).
REQ-020 Write wb_addr=0, data=0xFFFFFFFF; read rs=0 -> out_rs_data=0.
REQ-021 Load to r3 in ID/EX; decode rs=3 -> stall_out=1, next out_valid=0; following cycle instruction issues with out_valid=1.
REQ-022 in_imm=0x8001 -> out_sext_imm=0xFFFF8001, out_sext_imm_sl2=0xFFFE0004, out_zext_imm=0x00008001.
REQ-023 ex_stall=1 for 2 cycles -> outputs frozen; flush with ex_stall=1 -> out_valid=0; reset mid-stall -> all outputs 0 and stall_out=0.
